// File: rtl/histogram_equalizer_lut.sv
// Histogram equalization LUT builder and pixel remapper.
// The block accepts 256 histogram bins in order and accumulates them into a
// CDF RAM. It then derives one LUT entry per bin with a 34-cycle restoring
// divide. Once the LUT is complete it remaps one pixel per cycle.
module histogram_equalizer_lut #(
    parameter int PIXELS = 76800,
    parameter int BINS   = 256,
    parameter int CNT_W  = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             start_i,
    input  logic             hist_valid_i,
    output logic             hist_ready_o,
    input  logic [7:0]       hist_bin_i,
    input  logic [CNT_W-1:0] hist_count_i,
    input  logic             pix_valid_i,
    input  logic [7:0]       pix_i,
    output logic             pix_valid_o,
    output logic [7:0]       pix_o,
    output logic             lut_ready_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int BIN_W = 8;
    localparam int ACC_W = CNT_W + 1;
    localparam int DIV_W = 32;
    localparam logic [BIN_W-1:0] LAST_BIN   = BIN_W'(BINS - 1);
    localparam logic [ACC_W-1:0] PIXELS_ACC = ACC_W'(PIXELS);
    localparam logic [5:0]       CYC_NUM    = 6'd0;
    localparam logic [5:0]       CYC_LAST   = 6'd33;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   cdf_acc_reg, cdf_acc_next;
    logic [BIN_W-1:0]   bin_exp_reg, bin_exp_next;
    logic [ACC_W-1:0]   cdf_min_reg, cdf_min_next;
    logic               cdf_min_found_reg, cdf_min_found_next;
    logic [ACC_W-1:0]   denom_reg, denom_next;
    logic [BIN_W-1:0]   k_reg, k_next;
    logic [5:0]         cyc_reg, cyc_next;
    logic [DIV_W-1:0]   quo_reg, quo_next;
    logic [ACC_W-1:0]   rem_reg, rem_next;
    logic               pix_valid_reg;
    logic [7:0]         pix_reg;

    // Block RAMs; neither is cleared by reset.
    logic [ACC_W-1:0]   cdf_ram [BINS];
    logic [7:0]         lut_ram [BINS];
    logic [ACC_W-1:0]   cdf_rd_reg;

    logic               cdf_we;
    logic [ACC_W-1:0]   cdf_wdata;
    logic               lut_we;
    logic [7:0]         lut_wdata;
    logic               pix_fire;

    logic [ACC_W-1:0]   acc_sum;
    logic [ACC_W-1:0]   diff;
    logic [DIV_W-1:0]   num;
    logic [ACC_W:0]     rem_shift;

    assign pix_fire = en_i && (state_reg == ST_DONE) && pix_valid_i;

    // Next-state, datapath and RAM write control.
    always_comb begin
        state_next         = state_reg;
        cdf_acc_next       = cdf_acc_reg;
        bin_exp_next       = bin_exp_reg;
        cdf_min_next       = cdf_min_reg;
        cdf_min_found_next = cdf_min_found_reg;
        denom_next         = denom_reg;
        k_next             = k_reg;
        cyc_next           = cyc_reg;
        quo_next           = quo_reg;
        rem_next           = rem_reg;
        cdf_we             = 1'b0;
        cdf_wdata          = '0;
        lut_we             = 1'b0;
        lut_wdata          = '0;

        acc_sum   = cdf_acc_reg + ACC_W'(hist_count_i);
        diff      = (cdf_rd_reg >= cdf_min_reg) ? (cdf_rd_reg - cdf_min_reg) : '0;
        num       = DIV_W'(diff) * DIV_W'(255) + DIV_W'(denom_reg >> 1);
        rem_shift = {rem_reg, quo_reg[DIV_W-1]};

        if (en_i) begin
            case (state_reg)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_i) begin
                        state_next         = ST_LOAD;
                        cdf_acc_next       = '0;
                        bin_exp_next       = '0;
                        cdf_min_found_next = 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (hist_valid_i) begin
                        if (hist_bin_i != bin_exp_reg) begin
                            state_next = ST_ERR;
                        end else begin
                            cdf_acc_next = acc_sum;
                            cdf_we       = 1'b1;
                            cdf_wdata    = acc_sum;
                            bin_exp_next = bin_exp_reg + 1'b1;
                            if (!cdf_min_found_reg && (acc_sum != '0)) begin
                                cdf_min_next       = acc_sum;
                                cdf_min_found_next = 1'b1;
                            end
                            if (bin_exp_reg == LAST_BIN) begin
                                if (acc_sum != PIXELS_ACC) begin
                                    state_next = ST_ERR;
                                end else begin
                                    // cdf_min_next already covers a first
                                    // non-empty bin arriving on this beat.
                                    denom_next = PIXELS_ACC - cdf_min_next;
                                    k_next     = '0;
                                    cyc_next   = CYC_NUM;
                                    state_next = ST_CALC;
                                end
                            end
                        end
                    end
                end

                ST_CALC: begin
                    if (cyc_reg == CYC_NUM) begin
                        quo_next = num;
                        rem_next = '0;
                        cyc_next = cyc_reg + 1'b1;
                    end else if (cyc_reg == CYC_LAST) begin
                        lut_we = 1'b1;
                        if (denom_reg == '0) begin
                            lut_wdata = k_reg;
                        end else if (|quo_reg[DIV_W-1:8]) begin
                            lut_wdata = 8'hFF;
                        end else begin
                            lut_wdata = quo_reg[7:0];
                        end
                        cyc_next = CYC_NUM;
                        if (k_reg == LAST_BIN) begin
                            state_next = ST_DONE;
                        end else begin
                            k_next = k_reg + 1'b1;
                        end
                    end else begin
                        // One restoring-division step per cycle.
                        if (rem_shift >= {1'b0, denom_reg}) begin
                            rem_next = ACC_W'(rem_shift - {1'b0, denom_reg});
                            quo_next = {quo_reg[DIV_W-2:0], 1'b1};
                        end else begin
                            rem_next = rem_shift[ACC_W-1:0];
                            quo_next = {quo_reg[DIV_W-2:0], 1'b0};
                        end
                        cyc_next = cyc_reg + 1'b1;
                    end
                end

                default: state_next = ST_IDLE;
            endcase
        end
    end

    // FSM and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg         <= ST_IDLE;
            cdf_acc_reg       <= '0;
            bin_exp_reg       <= '0;
            cdf_min_reg       <= '0;
            cdf_min_found_reg <= 1'b0;
            denom_reg         <= '0;
            k_reg             <= '0;
            cyc_reg           <= '0;
            quo_reg           <= '0;
            rem_reg           <= '0;
        end else begin
            state_reg         <= state_next;
            cdf_acc_reg       <= cdf_acc_next;
            bin_exp_reg       <= bin_exp_next;
            cdf_min_reg       <= cdf_min_next;
            cdf_min_found_reg <= cdf_min_found_next;
            denom_reg         <= denom_next;
            k_reg             <= k_next;
            cyc_reg           <= cyc_next;
            quo_reg           <= quo_next;
            rem_reg           <= rem_next;
        end
    end

    // CDF RAM: write on each accepted bin. The read address follows k_next,
    // so cdf[k] is already registered when bin k enters its first CALC cycle.
    always_ff @(posedge clk_i) begin
        if (cdf_we) begin
            cdf_ram[bin_exp_reg] <= cdf_wdata;
        end
        if (en_i) begin
            cdf_rd_reg <= cdf_ram[k_next];
        end
    end

    // LUT RAM write at the last cycle of each bin's calculation.
    always_ff @(posedge clk_i) begin
        if (lut_we) begin
            lut_ram[k_reg] <= lut_wdata;
        end
    end

    // Pixel remap: registered LUT read gives one cycle of latency.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pix_valid_reg <= 1'b0;
            pix_reg       <= '0;
        end else begin
            pix_valid_reg <= pix_fire;
            if (pix_fire) begin
                pix_reg <= lut_ram[pix_i];
            end
        end
    end

    assign hist_ready_o = en_i && (state_reg == ST_LOAD);
    assign busy_o       = (state_reg == ST_LOAD) || (state_reg == ST_CALC);
    assign lut_ready_o  = (state_reg == ST_DONE);
    assign err_o        = (state_reg == ST_ERR);
    assign pix_valid_o  = pix_valid_reg;
    assign pix_o        = pix_reg;

endmodule

// File: tb/tb_histogram_equalizer_lut.sv
// Testbench for histogram_equalizer_lut.
// The LUT is predicted from the equalization formula applied to each frame's
// histogram. That prediction is compared against the remapped pixel stream.
module tb_histogram_equalizer_lut;

    localparam int PIXELS = 76800;
    localparam int BINS   = 256;
    localparam int CNT_W  = 24;
    localparam int CALC_CYCLES = 8704;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             en_i;
    logic             start_i;
    logic             hist_valid_i;
    logic             hist_ready_o;
    logic [7:0]       hist_bin_i;
    logic [CNT_W-1:0] hist_count_i;
    logic             pix_valid_i;
    logic [7:0]       pix_i;
    logic             pix_valid_o;
    logic [7:0]       pix_o;
    logic             lut_ready_o;
    logic             busy_o;
    logic             err_o;

    int checks = 0;
    int errors = 0;
    int unsigned frame_cnt [BINS];
    logic [7:0]  ref_lut [BINS];
    logic [7:0]  last_pix;

    histogram_equalizer_lut #(
        .PIXELS (PIXELS),
        .BINS   (BINS),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .start_i      (start_i),
        .hist_valid_i (hist_valid_i),
        .hist_ready_o (hist_ready_o),
        .hist_bin_i   (hist_bin_i),
        .hist_count_i (hist_count_i),
        .pix_valid_i  (pix_valid_i),
        .pix_i        (pix_i),
        .pix_valid_o  (pix_valid_o),
        .pix_o        (pix_o),
        .lut_ready_o  (lut_ready_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: equalized level = round(255 * (cdf - cdf_min) / (N - cdf_min)).
    task automatic build_ref();
        longint cdf [BINS];
        longint acc;
        longint cmin;
        longint denom;
        longint numer;
        longint q;
        bit     found;
        acc = 0;
        cmin = 0;
        found = 0;
        for (int k = 0; k < BINS; k++) begin
            acc += frame_cnt[k];
            cdf[k] = acc;
            if (!found && acc != 0) begin
                cmin = acc;
                found = 1;
            end
        end
        denom = PIXELS - cmin;
        for (int k = 0; k < BINS; k++) begin
            if (denom == 0) begin
                ref_lut[k] = 8'(k);
            end else begin
                numer = ((cdf[k] >= cmin) ? (cdf[k] - cmin) : 0) * 255 + denom / 2;
                q = numer / denom;
                ref_lut[k] = (q > 255) ? 8'hFF : 8'(q);
            end
        end
    endtask

    task automatic clear_frame();
        for (int k = 0; k < BINS; k++) frame_cnt[k] = 0;
    endtask

    task automatic random_frame();
        int lo;
        int hi;
        clear_frame();
        lo = $urandom_range(0, 120);
        hi = lo + $urandom_range(0, 135);
        for (int i = 0; i < PIXELS; i++) begin
            frame_cnt[$urandom_range(hi, lo)]++;
        end
    endtask

    // Pulses start and streams all 256 bins in order.
    task automatic send_frame();
        int accepted;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("load_ready", hist_ready_o, 1);
        check("load_lut_ready_low", lut_ready_o, 0);
        check("load_busy", busy_o, 1);
        accepted = 0;
        for (int b = 0; b < BINS; b++) begin
            hist_valid_i = 1'b1;
            hist_bin_i   = 8'(b);
            hist_count_i = CNT_W'(frame_cnt[b]);
            if (hist_ready_o) accepted++;
            tick();
        end
        hist_valid_i = 1'b0;
        check("bins_accepted", accepted, BINS);
    endtask

    // Counts clock edges from LOAD exit until lut_ready_o, optionally with an
    // enable gap. Pixels offered early in CALC must be ignored.
    task automatic wait_lut(input int exp_cycles, input int gap_at, input int gap_len);
        int n;
        n = 0;
        while (!lut_ready_o && n < 20000) begin
            if (gap_len > 0 && n == gap_at) en_i = 1'b0;
            if (gap_len > 0 && n == gap_at + gap_len) en_i = 1'b1;
            if (n < 20) begin
                pix_valid_i = 1'b1;
                pix_i = 8'($urandom);
            end else begin
                pix_valid_i = 1'b0;
            end
            tick();
            n++;
            if (n == 10) begin
                check("pix_ignored_in_calc", pix_valid_o, 0);
                check("busy_in_calc", busy_o, 1);
            end
        end
        en_i = 1'b1;
        pix_valid_i = 1'b0;
        check("lut_latency", n, exp_cycles);
        check("done_busy_low", busy_o, 0);
        check("done_err_low", err_o, 0);
    endtask

    task automatic pixel(input logic [7:0] v);
        pix_valid_i = 1'b1;
        pix_i = v;
        tick();
        check("pix_valid", pix_valid_o, 1);
        check("pix_value", pix_o, ref_lut[v]);
        last_pix = ref_lut[v];
    endtask

    task automatic pixel_idle();
        pix_valid_i = 1'b0;
        tick();
        check("pix_valid_idle", pix_valid_o, 0);
        check("pix_hold", pix_o, last_pix);
    endtask

    task automatic pixel_sweep(input int n);
        for (int i = 0; i < n; i++) pixel(8'($urandom));
        pixel_idle();
    endtask

    initial begin
        rst_ni = 1'b0;
        en_i = 1'b1;
        start_i = 1'b0;
        hist_valid_i = 1'b0;
        hist_bin_i = '0;
        hist_count_i = '0;
        pix_valid_i = 1'b0;
        pix_i = '0;
        last_pix = '0;
        tick();
        tick();
        check("rst_hist_ready", hist_ready_o, 0);
        check("rst_pix_valid", pix_valid_o, 0);
        check("rst_pix", pix_o, 0);
        check("rst_lut_ready", lut_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        rst_ni = 1'b1;
        tick();

        // Uniform histogram gives an identity LUT.
        clear_frame();
        for (int k = 0; k < BINS; k++) frame_cnt[k] = 300;
        build_ref();
        send_frame();
        wait_lut(CALC_CYCLES, 0, 0);
        pixel(8'd0);
        pixel(8'd77);
        pixel(8'd255);
        pixel_idle();
        pixel_sweep(32);

        // Histogram bins are not accepted outside LOAD.
        hist_valid_i = 1'b1;
        check("hist_ready_in_done", hist_ready_o, 0);
        tick();
        check("done_holds", lut_ready_o, 1);
        hist_valid_i = 1'b0;

        // Two-level image, started directly from DONE.
        clear_frame();
        frame_cnt[10] = 38400;
        frame_cnt[200] = 38400;
        build_ref();
        send_frame();
        wait_lut(CALC_CYCLES, 0, 0);
        pixel(8'd10);
        pixel(8'd200);
        pixel(8'd199);
        pixel_sweep(32);

        // Single-level image: zero denominator gives an identity LUT.
        clear_frame();
        frame_cnt[128] = PIXELS;
        build_ref();
        send_frame();
        wait_lut(CALC_CYCLES, 0, 0);
        pixel(8'd128);
        pixel(8'd3);
        pixel_idle();
        check("single_level_err", err_o, 0);

        // Random skewed histogram, with a 50-cycle enable gap mid-CALC.
        random_frame();
        build_ref();
        send_frame();
        wait_lut(CALC_CYCLES + 50, 1000, 50);
        pixel_sweep(64);

        // Histogram one pixel short ends in ERR.
        clear_frame();
        for (int k = 0; k < BINS; k++) frame_cnt[k] = 300;
        frame_cnt[0] = 299;
        send_frame();
        check("short_sum_err", err_o, 1);
        check("short_sum_lut_ready", lut_ready_o, 0);
        check("short_sum_busy", busy_o, 0);
        check("short_sum_ready", hist_ready_o, 0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("restart_err_clear", err_o, 0);
        check("restart_ready", hist_ready_o, 1);

        // Out-of-order bin: bins 0..3, then 5 instead of 4.
        for (int b = 0; b < 4; b++) begin
            hist_valid_i = 1'b1;
            hist_bin_i = 8'(b);
            hist_count_i = CNT_W'(300);
            tick();
        end
        hist_bin_i = 8'd5;
        check("bad_bin_offered", hist_ready_o, 1);
        tick();
        check("bad_bin_err", err_o, 1);
        check("bad_bin_ready_low", hist_ready_o, 0);
        hist_bin_i = 8'd6;
        tick();
        check("bad_bin_still_err", err_o, 1);
        hist_valid_i = 1'b0;

        // Reset around bin 100 of CALC aborts the frame.
        random_frame();
        build_ref();
        send_frame();
        for (int i = 0; i < 100 * 34 + 10; i++) tick();
        check("mid_calc_busy", busy_o, 1);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check("abort_busy", busy_o, 0);
        check("abort_lut_ready", lut_ready_o, 0);
        check("abort_err", err_o, 0);
        check("abort_hist_ready", hist_ready_o, 0);
        check("abort_pix_valid", pix_valid_o, 0);
        check("abort_pix", pix_o, 0);
        last_pix = 8'd0;

        // Fresh frame after the abort.
        send_frame();
        wait_lut(CALC_CYCLES, 0, 0);
        pixel_sweep(64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
